roach_clk_supervisor: RTL
=========================

# roach_clk_supervisor

Parametrised clock-health and reset sequencer for the ROACH infrastructure layer, running on `sys_clk`. It supervises `N_CLK` clock generator lock indications (DCM/MMCM, aux and ADC clocks) and issues a per-channel reset that releases only after a qualified stable lock. It also sequences the IDELAYCTRL reset and ready handshake, and keeps per-channel saturating lock-loss counters for software readback. It sits beside the clock infrastructure and drives the reset inputs of downstream clock-domain logic.

## Interface
Parameters:
- `N_CLK`, 4: number of supervised lock channels (1..16)
- `SYNC_STAGES`, 2: synchroniser depth for async inputs (>=2)
- `LOCK_STABLE_CYCLES`, 1024: consecutive synced-lock cycles required before release (>=2)
- `RST_HOLD_CYCLES`, 64: minimum channel reset hold after a lock loss (>=1)
- `IDELAY_RST_CYCLES`, 32: idelay_rst pulse length (>=1)
- `CNT_W`, 8: lock-loss counter width

Ports:
- `sys_clk`  in  1  sole clock
- `sys_rst`  in  1  synchronous, active-high reset
- `lock_in`  in  N_CLK  async lock flags, one per channel
- `chan_en`  in  N_CLK  channel enable; 0 excludes the channel
- `idelay_rdy_in`  in  1  async IDELAYCTRL RDY
- `cnt_sel`  in  clog2(N_CLK) (min 1)  loss-counter read select
- `cnt_clr`  in  1  clear all loss counters
- `chan_rst`  out  N_CLK  per-channel reset, active-high
- `chan_good`  out  N_CLK  channel in RUN
- `idelay_rst`  out  1  IDELAYCTRL reset
- `idelay_rdy`  out  1  idelay sequencer in IREADY
- `all_good`  out  1  AND over enabled channels of chan_good, AND idelay_rdy
- `loss_cnt`  out  CNT_W  selected channel's loss count

## Operation
- One clock, `sys_clk`. Reset is synchronous and active-high on `sys_rst`.
- `lock_in` and `idelay_rdy_in` pass through a `SYNC_STAGES` flop chain to give `lock_s` and `rdy_s`. The chain is not reset.
- Per-channel FSM: WAIT_LOCK, STABLE, RUN, HOLD. Each channel has one shared counter, wide enough for max(LOCK_STABLE, RST_HOLD).
  - WAIT_LOCK: if lock_s=1, go to STABLE with counter=1.
  - STABLE: if lock_s=0, go to WAIT_LOCK; this is not a loss. If the counter equals LOCK_STABLE_CYCLES, go to RUN. Otherwise increment the counter.
  - RUN: if lock_s=0, go to HOLD with counter=1 and increment the loss counter.
  - HOLD: lock_s is ignored. When the counter equals RST_HOLD_CYCLES, go to WAIT_LOCK; otherwise increment.
  - `chan_rst` is the registered value of (state != RUN). `chan_good` is the registered value of (state == RUN).
  - If chan_en=0, the FSM is forced to WAIT_LOCK, with chan_rst=1 and chan_good=0. The channel counts as true in `all_good`. Disabling a channel in RUN does not count as a loss.
- Idelay FSM: IRST, IWAIT, IREADY.
  - IRST: hold idelay_rst=1 for IDELAY_RST_CYCLES cycles, then go to IWAIT.
  - IWAIT: if rdy_s=1, go to IREADY.
  - IREADY: if rdy_s=0, go back to IRST and restart the full pulse.
- Loss counters saturate at 2^CNT_W-1. `cnt_clr` zeroes all counters. If clear and increment happen in the same cycle, clear wins and the result is 0.
- `loss_cnt` is registered from counter[cnt_sel]. An out-of-range cnt_sel reads 0.
- `all_good` is registered from the current chan_good, chan_en and idelay_rdy values.

## Timing
- Reset values:
  - chan_rst = all 1s; chan_good = 0; all_good = 0
  - idelay_rst = 1; idelay_rdy = 0; loss_cnt = 0
  - All FSMs in WAIT_LOCK or IRST, counters 0.
- sys_rst asserted mid-operation returns everything to the reset values on the next edge. Loss counters clear too.
- Synchroniser latency is SYNC_STAGES cycles.
- Lock release timing:
  - If lock_s first goes high in cycle c and stays high, chan_good first goes high in cycle c+LOCK_STABLE_CYCLES+1. chan_rst falls in the same cycle.
  - Any lock_s low during STABLE restarts qualification.
- Lock loss timing:
  - If lock_s goes low in RUN in cycle d, chan_good=0 and chan_rst=1 from cycle d+1, and the loss counter updates in cycle d+1.
  - The channel re-enters WAIT_LOCK in cycle d+RST_HOLD_CYCLES+1.
- Idelay timing:
  - idelay_rst is high from reset through cycle IDELAY_RST_CYCLES after sys_rst deasserts, counting the first deasserted cycle as 1.
  - idelay_rdy rises 1 cycle after rdy_s is seen high in IWAIT.
- `all_good` lags chan_good and idelay_rdy by 1 cycle.
- `loss_cnt` lags cnt_sel and counter updates by 1 cycle.

## Test plan
Bench parameters: N_CLK=3, SYNC=2, STABLE=16, HOLD=8, IDLY=12, CNT_W=8.

- **Power-up:** release sys_rst, then drive idelay_rdy_in=1 at cycle 20 and all lock_in=1 at cycle 0 -> idelay_rst high for cycles 1-12; chan_good[all] rises at cycle 19; idelay_rdy rises at cycle 23; all_good at cycle 24.
- **Lock glitch in STABLE:** drop lock_in[1] for 1 cycle at cycle 8 -> chan 1 requalifies from scratch; chan_good[1] late by the glitch offset; loss_cnt[1]=0.
- **Lock loss in RUN:** drop lock_in[0] for 3 cycles -> chan_rst[0] high, held at least 8 cycles, then requalified for 16 cycles; loss_cnt (sel=0) reads 1; all_good drops for the whole interval.
- **Saturation and clear:** 300 loss events on chan 2 -> loss_cnt=255; then assert cnt_clr on the same cycle as a loss -> loss_cnt=0.
- **Channel disable:** chan_en[2]=0 while lock_in[2]=0 -> all_good=1 with chan_rst[2]=1; re-enable -> chan 2 qualifies normally with no loss counted.
- **Idelay drop and reset mid-run:** deassert idelay_rdy_in -> idelay_rst is a fresh 12-cycle pulse and all_good=0; then assert sys_rst during HOLD -> all outputs return to reset values next cycle.

Source files
------------

// File: rtl/roach_clk_supervisor.sv
// roach_clk_supervisor: clock lock supervision, per-channel reset
// release, IDELAYCTRL reset sequencing and lock-loss counters.
module roach_clk_supervisor #(
    parameter int N_CLK              = 4,
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RST_HOLD_CYCLES    = 64,
    parameter int IDELAY_RST_CYCLES  = 32,
    parameter int CNT_W              = 8,
    localparam int SEL_W = (N_CLK > 1) ? $clog2(N_CLK) : 1
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [N_CLK-1:0] lock_in,
    input  logic [N_CLK-1:0] chan_en,
    input  logic             idelay_rdy_in,
    input  logic [SEL_W-1:0] cnt_sel,
    input  logic             cnt_clr,
    output logic [N_CLK-1:0] chan_rst,
    output logic [N_CLK-1:0] chan_good,
    output logic             idelay_rst,
    output logic             idelay_rdy,
    output logic             all_good,
    output logic [CNT_W-1:0] loss_cnt
);

    localparam int MAX_CYC = (LOCK_STABLE_CYCLES > RST_HOLD_CYCLES) ?
                             LOCK_STABLE_CYCLES : RST_HOLD_CYCLES;
    localparam int CW = $clog2(MAX_CYC + 1);
    localparam int IW = $clog2(IDELAY_RST_CYCLES + 1);

    typedef enum logic [1:0] {
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_HOLD
    } chan_state_t;

    typedef enum logic [1:0] {
        I_RST,
        I_WAIT,
        I_READY
    } idly_state_t;

    logic [N_CLK-1:0]       r_lock_sync [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] r_rdy_sync;
    logic [N_CLK-1:0]       w_lock_s;
    logic                   w_rdy_s;
    logic [N_CLK-1:0]       w_chan_rst;
    logic [N_CLK-1:0]       w_chan_good;
    logic [CNT_W-1:0]       w_loss [N_CLK];
    logic [CNT_W-1:0]       w_sel_cnt;

    // Metastability chains for the asynchronous lock and RDY flags.
    always_ff @(posedge sys_clk) begin
        r_lock_sync[0] <= lock_in;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            r_lock_sync[s] <= r_lock_sync[s-1];
        end
        r_rdy_sync <= {r_rdy_sync[SYNC_STAGES-2:0], idelay_rdy_in};
    end

    assign w_lock_s = r_lock_sync[SYNC_STAGES-1];
    assign w_rdy_s  = r_rdy_sync[SYNC_STAGES-1];

    for (genvar g = 0; g < N_CLK; g++) begin : g_chan
        chan_state_t      r_state;
        chan_state_t      w_state_nxt;
        logic [CW-1:0]    r_cnt;
        logic [CW-1:0]    w_cnt_nxt;
        logic             w_loss_inc;
        logic             r_rst;
        logic             r_good;
        logic [CNT_W-1:0] r_loss;

        // Lock qualification / hold sequencing for one channel.
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_loss_inc  = 1'b0;
            if (!chan_en[g]) begin
                w_state_nxt = S_WAIT_LOCK;
                w_cnt_nxt   = '0;
            end else begin
                unique case (r_state)
                    S_WAIT_LOCK: begin
                        if (w_lock_s[g]) begin
                            w_state_nxt = S_STABLE;
                            w_cnt_nxt   = CW'(1);
                        end
                    end
                    S_STABLE: begin
                        if (!w_lock_s[g]) begin
                            w_state_nxt = S_WAIT_LOCK;
                            w_cnt_nxt   = '0;
                        end else if (r_cnt == CW'(LOCK_STABLE_CYCLES)) begin
                            w_state_nxt = S_RUN;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + CW'(1);
                        end
                    end
                    S_RUN: begin
                        if (!w_lock_s[g]) begin
                            w_state_nxt = S_HOLD;
                            w_cnt_nxt   = CW'(1);
                            w_loss_inc  = 1'b1;
                        end
                    end
                    S_HOLD: begin
                        if (r_cnt == CW'(RST_HOLD_CYCLES)) begin
                            w_state_nxt = S_WAIT_LOCK;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + CW'(1);
                        end
                    end
                    default: begin
                        w_state_nxt = S_WAIT_LOCK;
                        w_cnt_nxt   = '0;
                    end
                endcase
            end
        end

        // State register; outputs follow the state being entered.
        always_ff @(posedge sys_clk) begin
            if (sys_rst) begin
                r_state <= S_WAIT_LOCK;
                r_cnt   <= '0;
                r_rst   <= 1'b1;
                r_good  <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_rst   <= (w_state_nxt != S_RUN);
                r_good  <= (w_state_nxt == S_RUN);
            end
        end

        // Saturating loss counter; clear beats a same-cycle loss.
        always_ff @(posedge sys_clk) begin
            if (sys_rst || cnt_clr) begin
                r_loss <= '0;
            end else if (w_loss_inc && (r_loss != '1)) begin
                r_loss <= r_loss + CNT_W'(1);
            end
        end

        assign w_chan_rst[g]  = r_rst;
        assign w_chan_good[g] = r_good;
        assign w_loss[g]      = r_loss;
    end

    idly_state_t   r_istate;
    idly_state_t   w_istate_nxt;
    logic [IW-1:0] r_icnt;
    logic [IW-1:0] w_icnt_nxt;
    logic          r_idelay_rst;
    logic          r_idelay_rdy;

    // IDELAYCTRL reset pulse and ready handshake.
    always_comb begin
        w_istate_nxt = r_istate;
        w_icnt_nxt   = r_icnt;
        unique case (r_istate)
            I_RST: begin
                if (r_icnt == IW'(IDELAY_RST_CYCLES - 1)) begin
                    w_istate_nxt = I_WAIT;
                    w_icnt_nxt   = '0;
                end else begin
                    w_icnt_nxt = r_icnt + IW'(1);
                end
            end
            I_WAIT: begin
                if (w_rdy_s) begin
                    w_istate_nxt = I_READY;
                end
            end
            I_READY: begin
                if (!w_rdy_s) begin
                    w_istate_nxt = I_RST;
                    w_icnt_nxt   = '0;
                end
            end
            default: begin
                w_istate_nxt = I_RST;
                w_icnt_nxt   = '0;
            end
        endcase
    end

    // Idelay state register with registered outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_istate     <= I_RST;
            r_icnt       <= '0;
            r_idelay_rst <= 1'b1;
            r_idelay_rdy <= 1'b0;
        end else begin
            r_istate     <= w_istate_nxt;
            r_icnt       <= w_icnt_nxt;
            r_idelay_rst <= (w_istate_nxt == I_RST);
            r_idelay_rdy <= (w_istate_nxt == I_READY);
        end
    end

    // Counter readback select; out-of-range selects read zero.
    always_comb begin
        w_sel_cnt = '0;
        for (int i = 0; i < N_CLK; i++) begin
            if (cnt_sel == SEL_W'(i)) begin
                w_sel_cnt = w_loss[i];
            end
        end
    end

    logic             r_all_good;
    logic [CNT_W-1:0] r_loss_cnt;

    // Summary health flag and registered counter readback.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_all_good <= 1'b0;
            r_loss_cnt <= '0;
        end else begin
            r_all_good <= (&(w_chan_good | ~chan_en)) & r_idelay_rdy;
            r_loss_cnt <= w_sel_cnt;
        end
    end

    assign chan_rst   = w_chan_rst;
    assign chan_good  = w_chan_good;
    assign idelay_rst = r_idelay_rst;
    assign idelay_rdy = r_idelay_rdy;
    assign all_good   = r_all_good;
    assign loss_cnt   = r_loss_cnt;

endmodule
